// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl
//   Drives the cycle/duty inputs of one PWM generator channel. A new
//   configuration is taken over a valid/ready port, held in shadow registers
//   and applied only on the last clock of a PWM period. When a non-zero step
//   is given, duty slews toward the target by at most `step` every (hold+1)
//   periods (soft-start / soft-stop).
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset (shared with generator)
//   cfg_valid    new configuration offered
//   cfg_ready    configuration can be accepted (low while a load is pending)
//   cfg_cycle    requested period in clocks (values below 2 are raised to 2)
//   cfg_duty     requested duty (limited to cycle-1)
//   cfg_step     max duty change per step; 0 = jump straight to target
//   cfg_hold     extra periods between steps
//   pwm_cycle    cycle to the generator
//   pwm_duty     duty to the generator
//   period_end   high on the last clock of each PWM period
//   busy         a configuration is pending or ramping
//   done         one-clock pulse when the target duty has been applied
module pwm_ramp_ctrl #(
    parameter int CYCLE_WIDTH = 8,
    parameter int DUTY_WIDTH  = CYCLE_WIDTH,
    parameter int HOLD_WIDTH  = 4,
    parameter int DEF_CYCLE   = 100,
    parameter int DEF_DUTY    = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [CYCLE_WIDTH-1:0] cfg_cycle,
    input  logic [DUTY_WIDTH-1:0]  cfg_duty,
    input  logic [DUTY_WIDTH-1:0]  cfg_step,
    input  logic [HOLD_WIDTH-1:0]  cfg_hold,
    output logic [CYCLE_WIDTH-1:0] pwm_cycle,
    output logic [DUTY_WIDTH-1:0]  pwm_duty,
    output logic                   period_end,
    output logic                   busy,
    output logic                   done
);

    localparam int CW = CYCLE_WIDTH;
    localparam int DW = DUTY_WIDTH;
    localparam int HW = HOLD_WIDTH;
    localparam int MW = ((CW > DW) ? CW : DW) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        RAMP = 2'd2
    } state_e;

    // Cycle below 2 would leave no room for a period boundary.
    function automatic logic [CW-1:0] clamp_cycle(input logic [CW-1:0] c);
        if (c < CW'(2)) return CW'(2);
        return c;
    endfunction

    // Duty is limited to cycle-1 so the generator always wraps its counter.
    function automatic logic [DW-1:0] clamp_duty(input logic [DW-1:0] d,
                                                 input logic [CW-1:0] c);
        logic [MW-1:0] lim;
        logic [MW-1:0] dx;
        lim = MW'(c) - MW'(1);
        dx  = MW'(d);
        if (dx > lim) return DW'(lim);
        return d;
    endfunction

    // One step from cur toward tgt, saturating at tgt in either direction.
    // Extra headroom bits keep the sum/difference from wrapping.
    function automatic logic [DW-1:0] step_toward(input logic [DW-1:0] cur,
                                                  input logic [DW-1:0] tgt,
                                                  input logic [DW-1:0] stp);
        logic signed [DW+1:0] c_s;
        logic signed [DW+1:0] t_s;
        logic signed [DW+1:0] s_s;
        logic signed [DW+1:0] n_s;
        c_s = $signed({2'b00, cur});
        t_s = $signed({2'b00, tgt});
        s_s = $signed({2'b00, stp});
        if (c_s < t_s) begin
            n_s = c_s + s_s;
            if (n_s > t_s) n_s = t_s;
        end else begin
            n_s = c_s - s_s;
            if (n_s < t_s) n_s = t_s;
        end
        return n_s[DW-1:0];
    endfunction

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   pwm_cycle_q, pwm_cycle_d;
    logic [DW-1:0]   pwm_duty_q, pwm_duty_d;
    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
    logic            done_q, done_d;

    // Shadow copy of the accepted configuration (already clamped).
    logic [CW-1:0]   cyc_t_q, cyc_t_d;
    logic [DW-1:0]   duty_t_q, duty_t_d;
    logic [DW-1:0]   step_q, step_d;
    logic [HW-1:0]   hold_q, hold_d;

    logic            accept;
    logic            pe;
    logic            hold_hit;
    logic [DW-1:0]   load_duty;
    logic [DW-1:0]   ramp_duty;

    assign pe       = (cnt_q == pwm_cycle_q - CW'(1));
    assign accept   = cfg_valid && cfg_ready;
    assign hold_hit = (hold_cnt_q == hold_q);
    assign ramp_duty = step_toward(pwm_duty_q, duty_t_q, step_q);

    // First value applied when a pending config loads; the extra clamp keeps
    // a falling first step inside the new, possibly shorter, period.
    always_comb begin
        load_duty = duty_t_q;
        if (step_q != '0)
            load_duty = clamp_duty(ramp_duty, cyc_t_q);
    end

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = PEND;
            PEND: if (pe) state_d = (load_duty == duty_t_q) ? IDLE : RAMP;
            RAMP: begin
                if (accept)
                    state_d = PEND;
                else if (pe && hold_hit && (ramp_duty == duty_t_q))
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM outputs ----------------
    always_comb begin
        cfg_ready = 1'b1;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin cfg_ready = 1'b1; busy = 1'b0; end
            PEND: begin cfg_ready = 1'b0; busy = 1'b1; end
            RAMP: begin cfg_ready = 1'b1; busy = 1'b1; end
            default: begin cfg_ready = 1'b1; busy = 1'b0; end
        endcase
    end

    // ---------------- datapath next values ----------------
    always_comb begin
        cnt_d       = pe ? '0 : cnt_q + CW'(1);
        pwm_cycle_d = pwm_cycle_q;
        pwm_duty_d  = pwm_duty_q;
        hold_cnt_d  = hold_cnt_q;
        done_d      = 1'b0;
        cyc_t_d     = cyc_t_q;
        duty_t_d    = duty_t_q;
        step_d      = step_q;
        hold_d      = hold_q;

        if (accept) begin
            cyc_t_d    = clamp_cycle(cfg_cycle);
            duty_t_d   = clamp_duty(cfg_duty, clamp_cycle(cfg_cycle));
            step_d     = cfg_step;
            hold_d     = cfg_hold;
            hold_cnt_d = '0;
        end

        case (state_q)
            PEND: begin
                if (pe) begin
                    pwm_cycle_d = cyc_t_q;
                    pwm_duty_d  = load_duty;
                    done_d      = (load_duty == duty_t_q);
                end
            end
            RAMP: begin
                // A same-edge accept abandons this period's step.
                if (!accept && pe) begin
                    if (hold_hit) begin
                        hold_cnt_d = '0;
                        pwm_duty_d = ramp_duty;
                        done_d     = (ramp_duty == duty_t_q);
                    end else begin
                        hold_cnt_d = hold_cnt_q + HW'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            pwm_cycle_q <= CW'(DEF_CYCLE);
            pwm_duty_q  <= DW'(DEF_DUTY);
            hold_cnt_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            pwm_cycle_q <= pwm_cycle_d;
            pwm_duty_q  <= pwm_duty_d;
            hold_cnt_q  <= hold_cnt_d;
            done_q      <= done_d;
        end
    end

    // Shadow contents are only read after an accept has written them.
    always_ff @(posedge clk) begin
        cyc_t_q  <= cyc_t_d;
        duty_t_q <= duty_t_d;
        step_q   <= step_d;
        hold_q   <= hold_d;
    end

    assign pwm_cycle  = pwm_cycle_q;
    assign pwm_duty   = pwm_duty_q;
    assign period_end = pe;
    assign done       = done_q;

endmodule
